// File: rtl/t1b_color_confirm.sv
// Confirms a sensor colour after CONFIRM_N identical fresh results and emits each confirmed change
// as a valid/ready event; also flags a stalled pipeline and records dropped events.
module t1b_color_confirm #(
    parameter int unsigned CONFIRM_N      = 3,
    parameter int unsigned TIMEOUT_CYC    = 4000,
    parameter int unsigned REPORT_REPEATS = 0
) (
    input  logic       clk_1MHz,
    input  logic       rst_n,
    input  logic [1:0] filter_in,
    input  logic [1:0] color_in,
    input  logic       det_ready,
    output logic       det_valid,
    output logic [1:0] det_color,
    output logic [7:0] det_seq,
    output logic       overflow,
    output logic       stall,
    output logic [3:0] match_cnt
);

    localparam logic [1:0]  ClearSlot     = 2'b10;
    localparam logic [3:0]  ConfirmN      = 4'(CONFIRM_N);
    localparam logic [15:0] TimeoutCyc    = 16'(TIMEOUT_CYC);
    localparam bit          ReportRepeats = (REPORT_REPEATS == 1);

    logic [1:0]  prev_filter_q;
    logic [1:0]  cand_q, cand_d;
    logic [3:0]  match_q, match_d;
    logic [1:0]  last_rep_q, last_rep_d;
    logic [15:0] idle_q, idle_d;
    logic        det_valid_q, det_valid_d;
    logic [1:0]  det_color_q, det_color_d;
    logic [7:0]  det_seq_q, det_seq_d;
    logic        overflow_q, overflow_d;

    logic new_res;
    logic stall_hit;
    logic confirm;
    logic emit;
    logic load;

    always_comb begin
        new_res   = (filter_in == ClearSlot) && (prev_filter_q != ClearSlot);
        stall_hit = !new_res && (idle_q == TimeoutCyc - 16'd1);

        idle_d = idle_q;
        if (new_res) begin
            idle_d = '0;
        end else if (idle_q != TimeoutCyc) begin
            idle_d = idle_q + 16'd1;
        end

        cand_d  = cand_q;
        match_d = match_q;
        if (new_res) begin
            if (color_in == 2'd0) begin
                cand_d  = 2'd0;
                match_d = 4'd0;
            end else if (color_in == cand_q) begin
                if (match_q != ConfirmN) begin
                    match_d = match_q + 4'd1;
                end
            end else begin
                cand_d  = color_in;
                match_d = 4'd1;
            end
        end else if (stall_hit) begin
            cand_d  = 2'd0;
            match_d = 4'd0;
        end

        // The candidate-change term only matters for CONFIRM_N == 1, where every new colour confirms.
        confirm = new_res && (color_in != 2'd0) && (match_d == ConfirmN) &&
                  ((match_q != ConfirmN) || (cand_q != color_in));
        emit    = confirm && (ReportRepeats || (color_in != last_rep_q));
        load    = emit && (!det_valid_q || det_ready);

        last_rep_d  = last_rep_q;
        det_valid_d = det_valid_q;
        det_color_d = det_color_q;
        det_seq_d   = det_seq_q;
        overflow_d  = overflow_q | (emit & ~load);

        if (stall_hit) begin
            last_rep_d = 2'd0;
        end

        if (load) begin
            det_valid_d = 1'b1;
            det_color_d = color_in;
            det_seq_d   = det_seq_q + 8'd1;
            last_rep_d  = color_in;
        end else if (det_valid_q && det_ready) begin
            det_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_1MHz or negedge rst_n) begin
        if (!rst_n) begin
            prev_filter_q <= 2'd0;
            cand_q        <= 2'd0;
            match_q       <= 4'd0;
            last_rep_q    <= 2'd0;
            idle_q        <= 16'd0;
            det_valid_q   <= 1'b0;
            det_color_q   <= 2'd0;
            det_seq_q     <= 8'd0;
            overflow_q    <= 1'b0;
        end else begin
            prev_filter_q <= filter_in;
            cand_q        <= cand_d;
            match_q       <= match_d;
            last_rep_q    <= last_rep_d;
            idle_q        <= idle_d;
            det_valid_q   <= det_valid_d;
            det_color_q   <= det_color_d;
            det_seq_q     <= det_seq_d;
            overflow_q    <= overflow_d;
        end
    end

    assign det_valid = det_valid_q;
    assign det_color = det_color_q;
    assign det_seq   = det_seq_q;
    assign overflow  = overflow_q;
    assign stall     = (idle_q == TimeoutCyc);
    assign match_cnt = match_q;

endmodule
